// File: rtl/taillight_monitor.sv
// Passive checker/decoder for the six-lamp turn-signal bus: decodes left/right/both sweeps,
// flags protocol violations, counts sweeps. Optional sticky error capture: TAILLIGHT_MON_STICKY_EN.
module taillight_monitor #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             L1,
  input  logic             L2,
  input  logic             L3,
  input  logic             R1,
  input  logic             R2,
  input  logic             R3,
`ifdef TAILLIGHT_MON_STICKY_EN
  input  logic             err_clr,
  output logic             err_sticky,
`endif
  output logic             left_done,
  output logic             right_done,
  output logic             both_done,
  output logic             err,
  output logic [2:0]       err_code,
  output logic             busy,
  output logic [CNT_W-1:0] left_cnt,
  output logic [CNT_W-1:0] right_cnt,
  output logic [CNT_W-1:0] both_cnt
);

  typedef enum logic [3:0] {
    StResync, StIdle, StLt1, StLt2, StLt3, StRt1, StRt2, StRt3, StBt1, StBt2, StBt3
  } state_t;

  state_t      r_state, w_state_d;
  logic [2:0]  w_ldec, w_rdec;
  logic        w_lill, w_rill;
  logic [1:0]  w_llvl, w_rlvl;
  logic [1:0]  w_side, w_lvl;
  logic [1:0]  w_cur_l, w_cur_r, w_exp_l, w_exp_r;
  logic        w_err;
  logic [2:0]  w_code;
  logic [2:0]  w_done;

  // Returns {illegal, level[1:0]} for one side's lamps {lamp3, lamp2, lamp1}.
  function automatic logic [2:0] side_dec(input logic [2:0] lamps);
    case (lamps)
      3'b000:  return 3'b000;
      3'b001:  return 3'b001;
      3'b011:  return 3'b010;
      3'b111:  return 3'b011;
      default: return 3'b100;
    endcase
  endfunction

  assign w_ldec = side_dec({L3, L2, L1});
  assign w_rdec = side_dec({R3, R2, R1});
  assign w_lill = w_ldec[2];
  assign w_rill = w_rdec[2];
  assign w_llvl = w_ldec[1:0];
  assign w_rlvl = w_rdec[1:0];

  // Active sides (bit0 left, bit1 right) and current level of the sweep state.
  always_comb begin
    w_side = 2'b00;
    w_lvl  = 2'd0;
    case (r_state)
      StLt1: begin w_side = 2'b01; w_lvl = 2'd1; end
      StLt2: begin w_side = 2'b01; w_lvl = 2'd2; end
      StLt3: begin w_side = 2'b01; w_lvl = 2'd3; end
      StRt1: begin w_side = 2'b10; w_lvl = 2'd1; end
      StRt2: begin w_side = 2'b10; w_lvl = 2'd2; end
      StRt3: begin w_side = 2'b10; w_lvl = 2'd3; end
      StBt1: begin w_side = 2'b11; w_lvl = 2'd1; end
      StBt2: begin w_side = 2'b11; w_lvl = 2'd2; end
      StBt3: begin w_side = 2'b11; w_lvl = 2'd3; end
      default: ;
    endcase
  end

  assign w_cur_l = w_side[0] ? w_lvl : 2'd0;
  assign w_cur_r = w_side[1] ? w_lvl : 2'd0;
  assign w_exp_l = (w_side[0] && w_lvl != 2'd3) ? w_lvl + 2'd1 : 2'd0;
  assign w_exp_r = (w_side[1] && w_lvl != 2'd3) ? w_lvl + 2'd1 : 2'd0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= StResync;
    else       r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    w_code    = 3'd0;
    w_done    = 3'b000;
    w_err     = 1'b0;
    case (r_state)
      StResync: begin
        if ({L3, L2, L1, R3, R2, R1} == 6'b0) w_state_d = StIdle;
      end
      StIdle: begin
        if (w_lill || w_rill) begin
          w_code = 3'd1;
        end else if (w_llvl == 2'd0 && w_rlvl == 2'd0) begin
          w_state_d = StIdle;
        end else if (w_llvl <= 2'd1 && w_rlvl <= 2'd1) begin
          if (w_llvl == 2'd1 && w_rlvl == 2'd1) w_state_d = StBt1;
          else if (w_llvl == 2'd1)              w_state_d = StLt1;
          else                                  w_state_d = StRt1;
        end else begin
          w_code = 3'd4;
        end
      end
      default: begin
        if (w_lill || w_rill) begin
          w_code = 3'd1;
        end else if ((!w_side[0] && w_llvl != 2'd0) || (!w_side[1] && w_rlvl != 2'd0) ||
                     (w_side == 2'b11 && w_llvl != w_rlvl)) begin
          w_code = 3'd2;
        end else if (w_llvl == w_cur_l && w_rlvl == w_cur_r) begin
          w_code = 3'd3;
        end else if (w_llvl != w_exp_l || w_rlvl != w_exp_r) begin
          w_code = 3'd4;
        end else if (w_lvl == 2'd3) begin
          w_state_d = StIdle;
          w_done    = (w_side == 2'b11) ? 3'b100 : {1'b0, w_side};
        end else begin
          // Sweep states of one side are encoded consecutively.
          w_state_d = state_t'(r_state + 4'd1);
        end
      end
    endcase
    if (w_code != 3'd0) begin
      w_err     = 1'b1;
      w_state_d = StResync;
    end
  end

  always_comb begin
    busy = !(r_state == StResync || r_state == StIdle);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      left_done  <= 1'b0;
      right_done <= 1'b0;
      both_done  <= 1'b0;
      err        <= 1'b0;
      err_code   <= 3'd0;
      left_cnt   <= '0;
      right_cnt  <= '0;
      both_cnt   <= '0;
`ifdef TAILLIGHT_MON_STICKY_EN
      err_sticky <= 1'b0;
`endif
    end else begin
      left_done  <= w_done[0];
      right_done <= w_done[1];
      both_done  <= w_done[2];
      err        <= w_err;
      if (w_done[0] && left_cnt != '1)  left_cnt  <= left_cnt + CNT_W'(1);
      if (w_done[1] && right_cnt != '1) right_cnt <= right_cnt + CNT_W'(1);
      if (w_done[2] && both_cnt != '1)  both_cnt  <= both_cnt + CNT_W'(1);
`ifdef TAILLIGHT_MON_STICKY_EN
      // An error on the same edge as err_clr wins; the first code is kept.
      if (w_err) begin
        if (!err_sticky) err_code <= w_code;
        err_sticky <= 1'b1;
      end else if (err_clr) begin
        err_sticky <= 1'b0;
        err_code   <= 3'd0;
      end
`else
      err_code <= w_code;
`endif
    end
  end

endmodule

// File: tb/tb_taillight_monitor.sv
// Self-checking bench for taillight_monitor: directed scenarios plus randomized traffic
// checked against a level/side arithmetic reference model.
module tb_taillight_monitor;
  localparam int CW  = 2;
  localparam int MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [2:0]    lv = 3'd0, rv = 3'd0;
  logic          left_done, right_done, both_done, err, busy;
  logic [2:0]    err_code;
  logic [CW-1:0] left_cnt, right_cnt, both_cnt;
  logic          clr = 1'b0;
`ifdef TAILLIGHT_MON_STICKY_EN
  logic          err_sticky;
`endif

  taillight_monitor #(.CNT_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .L1         (lv[0]),
    .L2         (lv[1]),
    .L3         (lv[2]),
    .R1         (rv[0]),
    .R2         (rv[1]),
    .R3         (rv[2]),
`ifdef TAILLIGHT_MON_STICKY_EN
    .err_clr    (clr),
    .err_sticky (err_sticky),
`endif
    .left_done  (left_done),
    .right_done (right_done),
    .both_done  (both_done),
    .err        (err),
    .err_code   (err_code),
    .busy       (busy),
    .left_cnt   (left_cnt),
    .right_cnt  (right_cnt),
    .both_cnt   (both_cnt)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  // Model: mode 0 = waiting for all-off, 1 = idle, 2 = sweeping; side bit0 left, bit1 right.
  int m_mode = 0, m_side = 0, m_lvl = 0;
  int m_cnt[3] = '{0, 0, 0};
  bit e_done[3] = '{0, 0, 0};
  bit e_err = 0;
  int m_code = 0;
  bit m_sticky = 0;
  int rd_pulses = 0;

  function automatic int lvl_of(input logic [2:0] p);
    case (p)
      3'b000:  return 0;
      3'b001:  return 1;
      3'b011:  return 2;
      3'b111:  return 3;
      default: return -1;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic model_step(input logic [2:0] l, input logic [2:0] r, input bit c);
    int a, b, ca, cb, ea, eb, code;
    bit hl, hr;
    a = lvl_of(l);
    b = lvl_of(r);
    code = 0;
    e_done = '{0, 0, 0};
    if (m_mode == 0) begin
      if (l == 3'd0 && r == 3'd0) m_mode = 1;
    end else if (m_mode == 1) begin
      if (a < 0 || b < 0) code = 1;
      else if (a == 0 && b == 0) m_mode = 1;
      else if (a <= 1 && b <= 1) begin
        m_mode = 2;
        m_side = a + 2 * b;
        m_lvl  = 1;
      end else code = 4;
    end else begin
      hl = (m_side & 1) != 0;
      hr = (m_side & 2) != 0;
      ca = hl ? m_lvl : 0;
      cb = hr ? m_lvl : 0;
      ea = (hl && m_lvl < 3) ? m_lvl + 1 : 0;
      eb = (hr && m_lvl < 3) ? m_lvl + 1 : 0;
      if (a < 0 || b < 0) code = 1;
      else if ((!hl && a != 0) || (!hr && b != 0) || (hl && hr && a != b)) code = 2;
      else if (a == ca && b == cb) code = 3;
      else if (a != ea || b != eb) code = 4;
      else if (m_lvl == 3) begin
        m_mode = 1;
        e_done[m_side - 1] = 1;
        if (m_cnt[m_side - 1] < MAX) m_cnt[m_side - 1]++;
      end else m_lvl++;
    end
    e_err = (code != 0);
    if (e_err) m_mode = 0;
`ifdef TAILLIGHT_MON_STICKY_EN
    if (e_err) begin
      if (!m_sticky) m_code = code;
      m_sticky = 1;
    end else if (c) begin
      m_sticky = 0;
      m_code   = 0;
    end
`else
    m_code = code;
`endif
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".left_done"},  32'(left_done),  32'(e_done[0]));
    chk({tag, ".right_done"}, 32'(right_done), 32'(e_done[1]));
    chk({tag, ".both_done"},  32'(both_done),  32'(e_done[2]));
    chk({tag, ".err"},        32'(err),        32'(e_err));
    chk({tag, ".err_code"},   32'(err_code),   32'(m_code));
    chk({tag, ".busy"},       32'(busy),       32'(m_mode == 2));
    chk({tag, ".left_cnt"},   32'(left_cnt),   32'(m_cnt[0]));
    chk({tag, ".right_cnt"},  32'(right_cnt),  32'(m_cnt[1]));
    chk({tag, ".both_cnt"},   32'(both_cnt),   32'(m_cnt[2]));
`ifdef TAILLIGHT_MON_STICKY_EN
    chk({tag, ".err_sticky"}, 32'(err_sticky), 32'(m_sticky));
`endif
  endtask

  // Drive one pattern, advance one clock, check every output.
  task automatic step(input logic [2:0] l, input logic [2:0] r, input string tag);
    lv = l;
    rv = r;
    model_step(l, r, clr);
    @(posedge clk);
    #1;
    if (right_done === 1'b1) rd_pulses++;
    check_all(tag);
  endtask

  task automatic sweep(input bit sl, input bit sr, input string tag);
    for (int n = 1; n <= 3; n++)
      step(sl ? 3'((1 << n) - 1) : 3'd0, sr ? 3'((1 << n) - 1) : 3'd0, tag);
    step(3'd0, 3'd0, tag);
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_cnt = '{0, 0, 0};
    e_done = '{0, 0, 0};
    e_err = 0;
    m_code = 0;
    m_sticky = 0;
  endtask

  initial begin
    int pick, nl, nr;
    bit hl, hr;
    // Reset state
    model_reset();
    #2;
    check_all("reset");
    @(posedge clk);
    #1 reset = 1'b0;

    step(3'd0, 3'd0, "resync_exit");
    sweep(1, 0, "left_sweep");
    sweep(0, 1, "right_sweep");
    sweep(1, 1, "both_sweep");

    step(3'b010, 3'd0, "illegal");
    step(3'b011, 3'd0, "absorb2");
    step(3'b111, 3'd0, "absorb3");
    step(3'd0, 3'd0, "absorb_off");
    sweep(1, 0, "left_after_illegal");

    step(3'b001, 3'd0, "stall_a");
    step(3'b001, 3'd0, "stall_b");
    step(3'd0, 3'd0, "stall_off");
    step(3'b011, 3'd0, "start_lvl2");
    step(3'd0, 3'd0, "start_off");
    step(3'b001, 3'd0, "early_a");
    step(3'b011, 3'd0, "early_b");
    step(3'd0, 3'd0, "early_off");
    step(3'd0, 3'd0, "early_idle");

    step(3'b001, 3'd0, "mis_lt_a");
    step(3'b011, 3'b001, "mis_lt_b");
    step(3'd0, 3'd0, "mis_lt_off");
    step(3'b001, 3'b001, "mis_bt_a");
    step(3'b011, 3'b001, "mis_bt_b");
    step(3'd0, 3'd0, "mis_bt_off");

    rd_pulses = 0;
    for (int k = 0; k < 5; k++) sweep(0, 1, "sat_right");
    chk("sat_right_pulses", 32'(rd_pulses), 32'd5);
    chk("sat_right_cnt", 32'(right_cnt), 32'(MAX));

    // Reset in the middle of a left sweep
    step(3'b001, 3'd0, "mid_a");
    step(3'b011, 3'd0, "mid_b");
    reset = 1'b1;
    model_reset();
    #2;
    check_all("mid_reset");
    @(posedge clk);
    #1 reset = 1'b0;
    step(3'b111, 3'd0, "mid_absorb");
    step(3'd0, 3'd0, "mid_off");
    sweep(1, 0, "mid_left");

`ifdef TAILLIGHT_MON_STICKY_EN
    step(3'b001, 3'd0, "sticky_a");
    step(3'b001, 3'd0, "sticky_stall");
    step(3'd0, 3'd0, "sticky_off");
    step(3'b010, 3'd0, "sticky_illegal");
    step(3'd0, 3'd0, "sticky_off2");
    clr = 1'b1;
    step(3'd0, 3'd0, "sticky_clr");
    clr = 1'b0;
    step(3'd0, 3'd0, "sticky_after");
`endif

    // Randomized traffic: mostly protocol-correct patterns with random corruption.
    for (int i = 0; i < 1500; i++) begin
      clr = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 4) != 0) begin
        if (m_mode == 2) begin
          hl = (m_side & 1) != 0;
          hr = (m_side & 2) != 0;
          nl = (hl && m_lvl < 3) ? m_lvl + 1 : 0;
          nr = (hr && m_lvl < 3) ? m_lvl + 1 : 0;
          step(3'((1 << nl) - 1), 3'((1 << nr) - 1), "rand_seq");
        end else begin
          pick = $urandom_range(0, 3);
          step(3'(pick & 1), 3'(pick >> 1), "rand_start");
        end
      end else begin
        step(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), "rand_any");
      end
    end
    clr = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/taillight_monitor.md
Name: taillight_monitor

Overview:
Passive checker and decoder for the six-lamp turn-signal bus driven by the team's tail-light sequencer. It samples L1..L3 and R1..R3 every clock and decodes completed left, right and both-side sweeps. It flags illegal, stalled, out-of-order or mismatched lamp patterns and keeps saturating per-direction sweep counters. It sits beside the sequencer on the same clock and is used both in the board-level self-test and as a bench monitor.

Parameters:
CNT_W, 8, width of each sweep counter (minimum 2)

Ports:
clk  in  1  clock; all sampling on the rising edge
reset  in  1  asynchronous, active-high
L1, L2, L3  in  1 each  left lamps; L1 is innermost
R1, R2, R3  in  1 each  right lamps; R1 is innermost
left_done  out  1  one-cycle pulse: left sweep completed
right_done  out  1  one-cycle pulse: right sweep completed
both_done  out  1  one-cycle pulse: both-side sweep completed
err  out  1  one-cycle pulse: protocol violation detected
err_code  out  3  violation code (see Behaviour)
busy  out  1  high while a sweep is in progress
left_cnt, right_cnt, both_cnt  out  CNT_W each  saturating completed-sweep counters

Behaviour:
- Side level, decoded per side from the sampled lamps:
  - 000 = level 0; 001 = level 1 (lamp 1 only); 011 = level 2 (lamps 1+2); 111 = level 3.
  - Any other combination is illegal, e.g. lamp 2 lit without lamp 1.
- Inputs are synchronous to clk; no synchronizers.
- States: RESYNC, IDLE, LT1, LT2, LT3, RT1, RT2, RT3, BT1, BT2, BT3. Encoding is free.
- Reset: state = RESYNC. All pulses, err_code, busy and all counters = 0.
- RESYNC: all-off moves to IDLE. Any other pattern stays in RESYNC. No error is raised in this state.
- IDLE:
  - All-off: stay.
  - L=1, R=0: go to LT1. L=0, R=1: go to RT1. L=1, R=1: go to BT1.
  - Any other pattern: error.
- LTn (n < 3): expect L=n+1, R=0. RTn (n < 3): expect L=0, R=n+1. BTn (n < 3): expect L=R=n+1.
- xT3: expect all-off. On all-off go to IDLE, pulse the matching *_done and increment its counter.
- Counters saturate at 2^CNT_W-1.
- Each sweep step lasts exactly one cycle. The sequencer always shows at least one all-off cycle between sweeps.
- On any error: pulse err for one cycle, load err_code, go to RESYNC.
- err_code values, highest priority first:
  - 1 = illegal side pattern.
  - 2 = side mismatch: a lamp lit on the wrong side for the current sweep, or unequal levels while in BTn.
  - 3 = stall: the pattern equals the one that caused entry into the current state.
  - 4 = order: any other unexpected legal pattern, including a level skip, an early all-off, or a start at level 2 or 3 from IDLE.
- Timing: *_done, err, err_code and counter updates are registered. They take effect at the same edge that samples the triggering pattern. Pulses are high for exactly that one cycle.
- busy = state in {LT*, RT*, BT*}, registered with the state.
- err_code reads 0 whenever err is low (non-sticky build).
- Simultaneous events cannot occur: at most one of left_done, right_done, both_done or err pulses per cycle.
- Reset mid-sweep: outputs return to reset values at once. After release, the rest of the partial sweep is absorbed silently in RESYNC.

Optional Feature:
TAILLIGHT_MON_STICKY_EN
- Defined:
  - Adds input err_clr (1 bit) and output err_sticky (1 bit).
  - The first error sets err_sticky and latches its code in err_code.
  - Later errors do not overwrite the code while err_sticky = 1.
  - err_clr clears both at the next edge; an error on the same edge wins.
  - err still pulses on every error.
  - Reset clears err_sticky and err_code.
- Not defined: the ports do not exist, and err_code is valid only during the err pulse.

Test Plan:
- Sweep decoding: reset; drive off, 001/000, 011/000, 111/000, off.
  - Expect left_done high one cycle at the final off edge, left_cnt=1, err never set.
  - Repeat for right and both; expect right_cnt=1 and both_cnt=1 respectively.
- Illegal pattern: in IDLE drive L=010 → err pulse, err_code=1.
  - Then drive L=011, 111 → no further err.
  - Then off, then a full left sweep → left_done fires.
- Stall and order: from LT1 hold L=001 a second cycle → err_code=3.
  - Separately, from IDLE drive L=011 → err_code=4.
  - Separately, from LT2 drive off → err_code=4.
- Side mismatch: in LT1 drive L=011, R=001 → err_code=2.
  - In BT1 drive L=011, R=001 → err_code=2.
- Saturation and reset: with CNT_W=2 run 5 right sweeps → right_cnt=3 and right_done pulses 5 times.
  - Assert reset during LT2 → all outputs 0; drive 111 then off → no err; next sweep decodes normally.
- Sticky build (TAILLIGHT_MON_STICKY_EN): cause a code-3 error, then a code-1 error → err_code stays 3, err pulses twice.
  - Pulse err_clr → err_sticky=0, err_code=0 next cycle.
